// File: rtl/spi3w_reg_slave.sv
// 3-wire SPI responder fronting a byte-addressed register file, with a fabric
// read/write port and write strobes exported for every completed SPI data byte.
`timescale 1ns / 1ps

module spi3w_reg_slave #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                 clk_20m,
  input  logic                 rstn,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 sdio_i,
  output logic                 sdio_o,
  output logic                 sdio_oe,
  input  logic                 lcl_we,
  input  logic [ADDR_BITS-1:0] lcl_addr,
  input  logic [7:0]           lcl_wdata,
  output logic [7:0]           lcl_rdata,
  output logic                 wr_stb,
  output logic [12:0]          wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {S_IDLE, S_INSTR, S_WDATA, S_RDATA, S_WAIT_CS} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_sclk_sync, r_cs_sync;
  logic [1:0]  r_sdio_sync;
  logic [14:0] r_shift;
  logic [7:0]  r_tx;
  logic [3:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic        r_stream;
  logic [12:0] r_addr;
  logic [7:0]  r_regs [DEPTH];

  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs, w_sdio;
  logic [15:0] w_shift_nxt;
  logic        w_hdr_done, w_byte_wr, w_byte_rd, w_last_byte, w_addr_hit;
  logic [12:0] w_addr_dec, w_rd_addr;
  logic [7:0]  w_rd_byte;

  // Index [1] is the second synchronizer stage; [2] only exists to find edges.
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs        = ~r_cs_sync[1];
  assign w_sdio      = r_sdio_sync[1];

  assign w_shift_nxt = {r_shift, w_sdio};
  assign w_hdr_done  = (r_state == S_INSTR) && w_sclk_rise && (r_bit_cnt == 4'd15);
  assign w_byte_wr   = (r_state == S_WDATA) && w_sclk_rise && (r_bit_cnt == 4'd7);
  assign w_byte_rd   = (r_state == S_RDATA) && w_sclk_rise && (r_bit_cnt == 4'd8);
  assign w_last_byte = !r_stream && (r_byte_cnt == 2'd0);
  assign w_addr_dec  = r_addr - 13'd1;
  assign w_addr_hit  = (r_addr >> ADDR_BITS) == 13'd0;

  // The header's last rise reads the addressed byte; later reloads read the next lower one.
  assign w_rd_addr = (r_state == S_INSTR) ? w_shift_nxt[12:0] : w_addr_dec;
  assign w_rd_byte = ((w_rd_addr >> ADDR_BITS) == 13'd0) ? r_regs[w_rd_addr[ADDR_BITS-1:0]] : 8'h00;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_sdio_sync <= 2'b00;
      r_state     <= S_IDLE;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_sdio_sync <= {r_sdio_sync[0], sdio_i};
      r_state     <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs) w_state_nxt = S_INSTR;
        S_INSTR: if (w_hdr_done) w_state_nxt = w_shift_nxt[15] ? S_RDATA : S_WDATA;
        S_WDATA: if (w_byte_wr && w_last_byte) w_state_nxt = S_WAIT_CS;
        S_RDATA: if (w_byte_rd && w_last_byte) w_state_nxt = S_WAIT_CS;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // NOTE: the register file has a reset because every byte must read back RESET_VAL after rstn.
  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VAL;
      r_shift    <= '0;
      r_tx       <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_stream   <= 1'b0;
      r_addr     <= '0;
      sdio_o     <= 1'b0;
      sdio_oe    <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      lcl_rdata  <= RESET_VAL;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= w_cs;
      lcl_rdata <= r_regs[lcl_addr];
      // Fabric write comes first so a same-cycle SPI write to the same byte wins.
      if (lcl_we) r_regs[lcl_addr] <= lcl_wdata;

      if (w_cs_rise) begin
        frame_err <= (r_state == S_INSTR) || (r_bit_cnt != 4'd0);
        sdio_oe   <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_bit_cnt <= '0;
          S_INSTR: if (w_sclk_rise) begin
            r_shift   <= w_shift_nxt[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_hdr_done) begin
              r_bit_cnt  <= '0;
              r_addr     <= w_shift_nxt[12:0];
              r_stream   <= &w_shift_nxt[14:13];
              r_byte_cnt <= w_shift_nxt[14:13];
              r_tx       <= w_rd_byte;
            end
          end
          S_WDATA: if (w_sclk_rise) begin
            r_shift   <= w_shift_nxt[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_byte_wr) begin
              if (w_addr_hit) r_regs[r_addr[ADDR_BITS-1:0]] <= w_shift_nxt[7:0];
              wr_stb     <= 1'b1;
              wr_addr    <= r_addr;
              wr_data    <= w_shift_nxt[7:0];
              r_bit_cnt  <= '0;
              r_addr     <= w_addr_dec;
              r_byte_cnt <= r_byte_cnt - 2'd1;
            end
          end
          S_RDATA: begin
            if (w_sclk_fall && (r_bit_cnt != 4'd8)) begin
              sdio_oe   <= 1'b1;
              sdio_o    <= r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_byte_rd) begin
              r_bit_cnt  <= '0;
              r_addr     <= w_addr_dec;
              r_byte_cnt <= r_byte_cnt - 2'd1;
              r_tx       <= w_rd_byte;
              if (w_last_byte) sdio_oe <= 1'b0;
            end
          end
          default: sdio_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/spi3w_reg_slave.md
# spi3w_reg_slave

Synthesizable 3-wire SPI responder that emulates a byte-addressed register file behind a 16-bit instruction header (R/W, W1:W0, 13-bit address). It receives frames on the shared sclk/cs_n/sdio lines and answers reads by driving sdio after the header. It serves as the far end of the clk_20m SPI master: a loopback target for board bring-up and the device model in master-side benches. Register writes are also exported to fabric as strobes.

## Interface
- ADDR_BITS, 8: implemented address bits; depth = 2**ADDR_BITS bytes.
- RESET_VAL, 8'h00: value of every register after reset.
- clk_20m  in  1  system clock; all logic is on its rising edge.
- rstn  in  1  reset, synchronous, active-low; clock clk_20m.
- spi_sclk  in  1  SPI clock, CPOL=0, asynchronous to clk_20m; period ≥ 16 clk_20m cycles.
- spi_cs_n  in  1  frame select, active-low, asynchronous.
- sdio_i  in  1  sdio pad input.
- sdio_o  out  1  sdio pad output data.
- sdio_oe  out  1  1 = drive sdio (pad T = ~sdio_oe).
- lcl_we  in  1  fabric write strobe.
- lcl_addr  in  ADDR_BITS  fabric write/read address.
- lcl_wdata  in  8  fabric write data.
- lcl_rdata  out  8  regfile[lcl_addr], registered.
- wr_stb  out  1  1-cycle pulse per completed SPI write byte.
- wr_addr  out  13  address of that byte.
- wr_data  out  8  data of that byte.
- busy  out  1  high while a frame is active (cs_n low, synchronized).
- frame_err  out  1  1-cycle pulse when cs_n rises mid-byte or mid-header.

## Operation
- sclk, cs_n, and sdio_i each pass through a 2-FF synchronizer. Rise and fall events come from the 2nd stage XOR a 3rd register.
- FSM states: IDLE, INSTR, WDATA, RDATA, WAIT_CS.
  - IDLE: on sync cs_n = 0 → INSTR; clear bit counter.
  - INSTR: shift sdio on each sclk rise, MSB first, 16 bits. Bit15 = R/W (1 = read), bits14:13 = W, bits12:0 = address.
    - After bit 16: byte count N = W+1 for W ∈ {0,1,2}; W = 3 means stream until cs_n rises.
    - Go to RDATA if read, else WDATA.
  - WDATA: shift 8 bits on sclk rises. On the 8th bit:
    - If addr[12:ADDR_BITS] == 0, write regfile[addr].
    - Always pulse wr_stb with wr_addr/wr_data.
    - Decrement addr modulo 2^13 and count bytes. When N is reached → WAIT_CS.
  - RDATA: on the header's final sclk rise, load the shift register with regfile[addr] (0x00 if out of range).
    - On each sclk fall: assert sdio_oe and drive sdio_o = shift MSB, then shift.
    - After 8 falls plus the following rise, decrement addr and load the next byte. After N bytes → WAIT_CS.
  - WAIT_CS: sdio_oe = 0; ignore sclk.
- Sync cs_n rise in any state → IDLE, sdio_oe = 0 on the same cycle, and the partial byte is discarded. Pulse frame_err if the state was INSTR, or if a data bit counter was nonzero.
- Fabric port: lcl_we writes regfile[lcl_addr].
  - If lcl_we and an SPI byte write hit in the same cycle, the SPI write wins for that address. A different address writes both.
- lcl_rdata = regfile[lcl_addr], 1-cycle latency.

## Timing
- Reset values: sdio_o 0, sdio_oe 0, wr_stb 0, wr_addr 0, wr_data 0, busy 0, frame_err 0, lcl_rdata RESET_VAL, FSM IDLE, all regs RESET_VAL.
- Edge detect latency: 3 clk_20m cycles from pin edge to internal event.
  - sdio_o changes 3–4 cycles after the pin sclk fall, inside the master's half-period of 32 cycles.
- wr_stb fires 1 cycle after the internal rise event of the 8th data bit. Regfile is updated on that same cycle.
- busy follows sync cs_n: asserts 3 cycles after the pin falls and deasserts 3 cycles after it rises.
- Turnaround: sdio_oe is first asserted on the first sclk fall after the 16th header rise, never earlier.
- Streaming reads/writes decrement the address. 0x0000 → 0x1FFF wraps, and that address is out of range, so reads return 0 and writes are dropped.

## Test plan
- Write 0x00A5 0x3C (W=0): regfile[0xA5] = 0x3C; one wr_stb with wr_addr 0x0A5, wr_data 0x3C; busy drops 3 cycles after cs_n rises.
- Preload [0x10] = 0x81 via lcl_we, then read 0x8010: sdio_oe high for exactly 8 falls; master receives 0x81; sdio_oe low after cs_n rises.
- Stream write W=3 at 0x0002 with 0x11, 0x22, 0x33, 0x44: regs [2..0] = 0x11, 0x22, 0x33; wr_addr 0x1FFF gets 0x44 (dropped); 4 wr_stb pulses.
- Raise cs_n after 12 header bits: frame_err pulses once, no write, FSM IDLE, sdio_oe 0. The next valid frame works.
- Collision: lcl_we to 0x05 with 0x77 on the same cycle as an SPI write of 0x99 to 0x05 → reg = 0x99. Repeat with lcl_addr 0x06: both writes land.
- Assert rstn low mid-read: sdio_oe = 0 next cycle, regs = RESET_VAL, and the frame after reset reads 0x00.
